// File: rtl/arb_pkg.sv
// Shared constants for the 16-way round-robin arbiter.
package arb_pkg;
    localparam int N_REQ = 16;
    localparam int ID_W  = 4;

    typedef logic [1:0] arb_state_t;

    localparam arb_state_t IDLE  = 2'd0;
    localparam arb_state_t GRANT = 2'd1;
    localparam arb_state_t GAP   = 2'd2;
endpackage

// File: rtl/Decoder4to16.sv
// 4-to-16 one-hot decoder with enable; output is all zeros when disabled.
module Decoder4to16 (
    input  logic [3:0]  a,
    input  logic        en,
    output logic [15:0] y
);
    // Drive the single addressed line when enabled.
    always_comb begin
        y = '0;
        if (en) y[a] = 1'b1;
    end
endmodule

// File: rtl/rr_pick16.sv
// Rotating priority picker: first requester at or after ptr, wrapping 15 -> 0.
module rr_pick16 import arb_pkg::*; (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  ptr,
    output logic             any,
    output logic [ID_W-1:0]  id
);
    logic [N_REQ-1:0] rot;
    logic [ID_W-1:0]  off;

    // Rotate so that bit 0 of rot corresponds to requester ptr.
    always_comb begin
        rot = '0;
        for (int i = 0; i < N_REQ; i++) begin
            rot[i] = req[ID_W'(i) + ptr];
        end
    end

    // Lowest set bit of the rotated vector; scanning downward leaves the lowest.
    always_comb begin
        off = '0;
        any = 1'b0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (rot[i]) begin
                off = ID_W'(i);
                any = 1'b1;
            end
        end
    end

    // Un-rotate back to an absolute index (4-bit wrap).
    assign id = ptr + off;
endmodule

// File: rtl/rr_arbiter16.sv
// Round-robin arbiter for 16 requesters with bounded hold time and a
// mandatory one-cycle gap after every release.
module rr_arbiter16 import arb_pkg::*; #(
    parameter int MAX_HOLD = 8,
    parameter int CW       = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic [15:0] req,
    output logic [15:0] gnt,
    output logic        gnt_valid,
    output logic [3:0]  gnt_id,
    output logic        expired
);
    arb_state_t      state_q, state_d;
    logic [ID_W-1:0] ptr_q, ptr_d;
    logic [ID_W-1:0] gnt_id_q, gnt_id_d;
    logic [CW-1:0]   hold_cnt_q, hold_cnt_d;
    logic            expired_q, expired_d;
    logic            pick_any;
    logic [ID_W-1:0] pick_id;

    rr_pick16 u_pick (
        .req (req),
        .ptr (ptr_q),
        .any (pick_any),
        .id  (pick_id)
    );

    // Next-state logic; a dropped request takes precedence over expiry, so
    // expired only fires when the owner was still requesting at the limit.
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        gnt_id_d   = gnt_id_q;
        hold_cnt_d = hold_cnt_q;
        expired_d  = 1'b0;
        case (state_q)
            GRANT: begin
                if (!en) begin
                    state_d = IDLE;
                    ptr_d   = gnt_id_q + 4'd1;
                end else if (!req[gnt_id_q]) begin
                    state_d = GAP;
                    ptr_d   = gnt_id_q + 4'd1;
                end else if (hold_cnt_q == CW'(MAX_HOLD)) begin
                    state_d   = GAP;
                    ptr_d     = gnt_id_q + 4'd1;
                    expired_d = 1'b1;
                end else begin
                    hold_cnt_d = hold_cnt_q + CW'(1);
                end
            end
            default: begin
                if (en && pick_any) begin
                    state_d    = GRANT;
                    gnt_id_d   = pick_id;
                    hold_cnt_d = CW'(1);
                end else begin
                    state_d = IDLE;
                end
            end
        endcase
    end

    // State, pointer, winner, hold counter and expiry pulse registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            gnt_id_q   <= '0;
            hold_cnt_q <= '0;
            expired_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            gnt_id_q   <= gnt_id_d;
            hold_cnt_q <= hold_cnt_d;
            expired_q  <= expired_d;
        end
    end

    assign gnt_valid = (state_q == GRANT);
    assign gnt_id    = gnt_id_q;
    assign expired   = expired_q;

    Decoder4to16 u_dec (
        .a  (gnt_id_q),
        .en (gnt_valid),
        .y  (gnt)
    );
endmodule

// File: tb/tb_rr_arbiter16.sv
// Randomized and directed bench for rr_arbiter16 against a behavioural model.
module tb_rr_arbiter16;
    localparam int MH = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic [15:0] req = 16'hFFFF;
    logic [15:0] gnt;
    logic        gnt_valid;
    logic [3:0]  gnt_id;
    logic        expired;

    int checks = 0;
    int errors = 0;

    // model: current owner (-1 = nobody), last winner, search start, hold count
    int m_owner = -1;
    int m_last  = 0;
    int m_ptr   = 0;
    int m_held  = 0;
    bit m_exp   = 1'b0;

    rr_arbiter16 #(.MAX_HOLD(MH), .CW(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .req       (req),
        .gnt       (gnt),
        .gnt_valid (gnt_valid),
        .gnt_id    (gnt_id),
        .expired   (expired)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Behavioural step: an owner keeps the resource while enabled and
    // requesting for at most MH cycles; any release leaves one empty cycle.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_owner = -1; m_last = 0; m_ptr = 0; m_held = 0; m_exp = 1'b0;
        end else begin
            m_exp = 1'b0;
            if (m_owner >= 0) begin
                if (!en || !req[m_owner] || m_held == MH) begin
                    m_exp   = en && req[m_owner] && (m_held == MH);
                    m_ptr   = (m_owner + 1) % 16;
                    m_owner = -1;
                end else begin
                    m_held++;
                end
            end else if (en && req != 16'h0) begin
                for (int k = 0; k < 16; k++) begin
                    if (m_owner < 0 && req[(m_ptr + k) % 16]) m_owner = (m_ptr + k) % 16;
                end
                m_last = m_owner;
                m_held = 1;
            end
        end
    end

    task automatic check_outputs();
        logic [15:0] exp_gnt;
        exp_gnt = (m_owner >= 0) ? (16'h1 << m_owner) : 16'h0;
        chk("gnt", gnt, exp_gnt);
        chk("gnt_valid", gnt_valid, m_owner >= 0);
        chk("gnt_id", gnt_id, m_last[3:0]);
        chk("expired", expired, m_exp);
    endtask

    // check this cycle's outputs at the falling edge, then apply new inputs
    task automatic cycle(input logic en_v, input logic [15:0] req_v);
        @(negedge clk);
        check_outputs();
        en  = en_v;
        req = req_v;
    endtask

    initial begin
        int dens [6] = '{10, 50, 90, 30, 100, 5};
        logic [15:0] r;

        // reset with all requests asserted
        repeat (3) @(negedge clk);
        chk("rst_gnt", gnt, 16'h0);
        chk("rst_valid", gnt_valid, 1'b0);
        chk("rst_id", gnt_id, 4'h0);
        chk("rst_exp", expired, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        en    = 1'b1;
        @(negedge clk);
        chk("rst_first_grant", gnt, 16'h0001);

        // rotation between ends of the vector
        repeat (14) cycle(1'b1, 16'h8001);
        // wrap: grant 14, idle, then 0 and 4 contend
        repeat (3) cycle(1'b1, 16'h4000);
        repeat (2) cycle(1'b1, 16'h0000);
        repeat (10) cycle(1'b1, 16'h0011);
        // early release of id 3
        repeat (2) cycle(1'b1, 16'h0000);
        repeat (2) cycle(1'b1, 16'h0008);
        repeat (3) cycle(1'b1, 16'h0000);
        // abort during grant to id 7, then re-enable
        repeat (2) cycle(1'b1, 16'h0080);
        repeat (2) cycle(1'b0, 16'h0080);
        repeat (3) cycle(1'b1, 16'h0080);

        // asynchronous reset between edges mid-grant
        cycle(1'b1, 16'h8001);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_gnt", gnt, 16'h0);
        chk("async_rst_valid", gnt_valid, 1'b0);
        chk("async_rst_exp", expired, 1'b0);
        @(negedge clk);
        check_outputs();
        rst_n = 1'b1;
        req   = 16'h8001;
        @(negedge clk);
        chk("post_rst_id0", gnt, 16'h0001);
        repeat (5) cycle(1'b1, 16'h8001);

        // randomized phases with sticky requests
        r = req;
        for (int p = 0; p < 6; p++) begin
            for (int c = 0; c < 500; c++) begin
                for (int i = 0; i < 16; i++) begin
                    if ($urandom_range(0, 9) == 0) r[i] = ($urandom_range(0, 99) < dens[p]);
                end
                cycle($urandom_range(0, 99) < 96, r);
            end
        end
        repeat (2) cycle(1'b1, 16'h0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/rr_arbiter16.md
# rr_arbiter16

Round-robin arbiter sharing one resource among 16 requesters. Each cycle it selects at most one requester, starting its search just after the last winner and wrapping around. It holds the grant while the winner keeps its request high, up to a configurable limit, then inserts a one-cycle gap before the next grant. The one-hot grant vector comes from the team's existing Decoder4to16, with its enable tied to the registered grant-valid.

## Interface
Parameters:
- `MAX_HOLD`, default 8: maximum consecutive grant cycles per winner. Legal range 1..255.
- `CW`, default 8: width of the hold counter. Must satisfy `2**CW > MAX_HOLD`.

Ports:
- `clk` in, 1: single clock, rising edge.
- `rst_n` in, 1: asynchronous active-low reset.
- `en` in, 1: arbiter enable. 0 aborts any grant and blocks new grants.
- `req` in, 16: request per requester, level-sensitive.
- `gnt` out, 16: one-hot grant, all zeros when no grant. Equals decode(`gnt_id`) gated by `gnt_valid`.
- `gnt_valid` out, 1: a grant is active this cycle.
- `gnt_id` out, 4: index of the current or most recent winner.
- `expired` out, 1: one-cycle pulse when a grant ends because it reached `MAX_HOLD`.

## Operation
- State register, 2 bits:
  - `IDLE`: no grant, searching.
  - `GRANT`: resource owned by `gnt_id`.
  - `GAP`: one dead cycle after every release.
- Rotation pointer `ptr[3:0]`: the search starts at `ptr` and wraps 15→0. The winner is the first index i in order `ptr, ptr+1, …` (mod 16) with `req[i]=1`.
- Transitions, evaluated at each rising edge:
  - `IDLE` → `GRANT` when `en` and `|req`. Latch `gnt_id` = winner, set `hold_cnt`=1.
  - `GRANT` → `GAP` when `!req[gnt_id]`, or when `hold_cnt==MAX_HOLD`. For the `MAX_HOLD` case, `expired`=1 on that transition. Otherwise stay in `GRANT` and increment `hold_cnt`.
  - `GRANT` → `IDLE` when `!en`. This is an abort: `expired` stays 0.
  - `GAP` → `GRANT` if `en` and `|req`, with a new search. Otherwise `GAP` → `IDLE`.
- On leaving `GRANT`, `ptr` ← `gnt_id`+1 (4-bit wrap, so 15+1 = 0).
- `gnt_valid` = (state==`GRANT`). The `gnt` decode is combinational from registered `gnt_id`/`gnt_valid`, so there are no glitches relative to the state.
- A requester that dropped its request, or was expired, is eligible again only by rotation. A sole requester is re-granted after the `GAP`.
- Changes to `req` bits other than `req[gnt_id]` during `GRANT` are ignored until the next search.

## Timing
- Reset values (asynchronous, immediate): state=`IDLE`, `ptr`=0, `gnt_id`=0, `hold_cnt`=0, `gnt`=16'h0000, `gnt_valid`=0, `expired`=0.
- Grant latency: `req` seen at edge k → `gnt_valid` high after edge k (visible in cycle k+1). One cycle.
- Release: `req[gnt_id]` low sampled at edge k → `gnt` zero after edge k. Next grant no earlier than after edge k+1, giving a guaranteed one-cycle gap.
- Maximum ownership: exactly `MAX_HOLD` cycles of `gnt_valid`. `expired` is high during the first `GAP` cycle.
- Simultaneous requests: resolved by the rotation order only. There is no fixed priority.
- `en` falling mid-grant: `gnt` drops after the next edge. `ptr` still advances.
- Reset mid-grant: outputs clear asynchronously. After reset, the first search starts at index 0.
- Worst-case wait for any requester with `req` held: 15×(`MAX_HOLD`+1)+1 cycles.

## Structure
- Shared package `arb_pkg`: state enum (`IDLE`, `GRANT`, `GAP`), `N_REQ`=16, `ID_W`=4.
- One natural sub-module, `rr_pick16`: combinational rotate, then priority-find, then un-rotate. Inputs `req`, `ptr`; outputs `any`, `id[3:0]`.
- Decoder4to16 is instantiated for `gnt`.
- Top level holds the FSM, `ptr`, `hold_cnt` and the `expired` register.

## Test plan
- Reset: `rst_n`=0 with `req`=16'hFFFF → `gnt`=0, `gnt_valid`=0, `gnt_id`=0. Release reset with `en`=1 → `gnt`=16'h0001 one cycle later.
- Rotation: `req`=16'h8001 held, `MAX_HOLD`=2 → grants alternate id 0 (2 cycles), gap, id 15 (2 cycles), gap, id 0. `expired` pulses each handoff.
- Wrap: `ptr`=15 after a grant to 14, then `req`=16'h0011 → winner is 0, then 4.
- Early release: id 3 granted, `req[3]` dropped after 1 cycle → `gnt`=0 next cycle, `expired`=0, `ptr`=4.
- Abort: `en`=0 during grant to id 7 → `gnt`=0 next cycle, no `expired`. Re-enable with `req`=16'h0080 → id 7 granted again.
- Async reset mid-grant: `rst_n` low between edges → `gnt` clears without a clock edge, `ptr` returns to 0.
